// File: rtl/shift_reg_pkg.sv
// Shared types and helpers for the n_piso_tx serial transmitter.
// Build option: define N_PISO_PARITY_EN to append an even-parity bit to every frame.
package shift_reg_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

`ifdef N_PISO_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    // Bits needed to hold values 0..v-1; never less than one bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    // Serial bits per frame for an n-bit word.
    function automatic int unsigned frame_len(input int unsigned n);
        return n + (PARITY_EN ? 1 : 0);
    endfunction

endpackage

// File: rtl/n_piso_bit_counter.sv
// Loadable down-counter tracking the bits left in the frame being transmitted.
// Saturates at zero; zero flag is combinational from the count.
module n_piso_bit_counter #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_value,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/n_piso_tx.sv
// Parallel-in serial-out transmitter: takes an N-bit word on a valid/ready handshake, sends it MSB first.
// Build option: N_PISO_PARITY_EN adds an even-parity bit after the data bits.
module n_piso_tx
    import shift_reg_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [N-1:0] data_in,
    output logic         d_out,
    output logic         out_valid,
    output logic         last_bit
);

    localparam int unsigned FRAME_LEN = frame_len(N);
    localparam int unsigned CNT_W     = clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    state_t           state;
    logic [N-1:0]     shreg;
    logic [CNT_W-1:0] count;
    logic             cnt_zero;
    logic             accept;
    logic             cnt_dec;
    logic             next_is_last;
`ifdef N_PISO_PARITY_EN
    logic             parity;
`endif

    assign load_ready   = (state == ST_IDLE);
    assign accept       = load_valid && load_ready;
    assign cnt_dec      = (state == ST_SHIFT) && !cnt_zero;
    assign next_is_last = (count == CNT_W'(1));

    n_piso_bit_counter #(
        .CNT_W(CNT_W)
    ) u_bit_counter (
        .clk       (clk),
        .clear     (clear),
        .load      (accept),
        .dec       (cnt_dec),
        .load_value(LAST_IDX),
        .count     (count),
        .zero      (cnt_zero)
    );

    // d_out is registered, so the first bit comes straight from data_in on accept
    // and each later bit is the one just below the current register MSB.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            d_out     <= 1'b0;
            out_valid <= 1'b0;
            last_bit  <= 1'b0;
`ifdef N_PISO_PARITY_EN
            parity    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_SHIFT;
                        shreg     <= data_in;
                        d_out     <= data_in[N-1];
                        out_valid <= 1'b1;
                        last_bit  <= 1'b0;
`ifdef N_PISO_PARITY_EN
                        parity    <= ^data_in;
`endif
                    end else begin
                        d_out     <= 1'b0;
                        out_valid <= 1'b0;
                        last_bit  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_zero) begin
                        state     <= ST_IDLE;
                        d_out     <= 1'b0;
                        out_valid <= 1'b0;
                        last_bit  <= 1'b0;
                    end else begin
                        shreg     <= shreg << 1;
                        out_valid <= 1'b1;
                        last_bit  <= next_is_last;
`ifdef N_PISO_PARITY_EN
                        d_out     <= next_is_last ? parity : shreg[N-2];
`else
                        d_out     <= shreg[N-2];
`endif
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
